// File: rtl/rgmii_rx_framer.sv
// rtl/rgmii_rx_framer.sv - GMII receive framer: preamble strip, CRC/length check, FCS strip, frame counters
module rgmii_rx_framer #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int STRIP_FCS     = 1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 gmii_rx_clk,
    input  logic                 rst,
    input  logic                 speed_1g,
    input  logic                 gmii_rx_dv,
    input  logic                 gmii_rx_er,
    input  logic [7:0]           gmii_rxd,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 m_err,
    output logic [CNT_WIDTH-1:0] frame_ok_cnt,
    output logic [CNT_WIDTH-1:0] frame_err_cnt
);
    localparam int          D       = (STRIP_FCS != 0) ? 5 : 1;
    localparam logic [2:0]  D_L     = 3'(D);
    localparam logic [15:0] MIN_L   = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_FRAME_LEN);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP, ST_END} state_t;

    state_t                r_state, w_next;
    logic                  r_speed;
    logic                  r_nib_hi;
    logic [3:0]            r_nib_lo;
    logic [15:0]           r_len;
    logic [31:0]           r_crc;
    logic [2:0]            r_cnt;
    logic [7:0]            r_line [0:4];
    logic                  r_er;
    logic [7:0]            r_m_data;
    logic                  r_m_valid, r_m_last, r_m_err;
    logic [CNT_WIDTH-1:0]  r_ok_cnt, r_err_cnt;

    logic                  w_idle_like, w_spd, w_sym_pre, w_sym_sfd;
    logic                  w_byte_vld, w_over, w_bad;
    logic [7:0]            w_byte;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // END behaves like IDLE for input decode so a preamble arriving at E+1 is accepted
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_END);
    assign w_spd       = w_idle_like ? speed_1g : r_speed;
    assign w_sym_pre   = w_spd ? (gmii_rxd == 8'h55) : (gmii_rxd[3:0] == 4'h5);
    assign w_sym_sfd   = w_spd ? (gmii_rxd == 8'hD5) : (gmii_rxd[3:0] == 4'hD);
    assign w_byte_vld  = (r_state == ST_DATA) && gmii_rx_dv && (r_speed || r_nib_hi);
    assign w_byte      = r_speed ? gmii_rxd : {gmii_rxd[3:0], r_nib_lo};
    assign w_over      = w_byte_vld && (r_len == MAX_L);
    assign w_bad       = r_er || (r_len < MIN_L) || (r_len > MAX_L) ||
                         (r_crc != RESIDUE) || r_nib_hi;

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_END: w_next = (gmii_rx_dv && w_sym_pre) ? ST_PREAMBLE : ST_IDLE;
            ST_PREAMBLE: begin
                if (!gmii_rx_dv)    w_next = ST_IDLE;
                else if (w_sym_sfd) w_next = ST_DATA;
                else if (w_sym_pre) w_next = ST_PREAMBLE;
                else                w_next = ST_IDLE;
            end
            ST_DATA: begin
                if (!gmii_rx_dv) w_next = ST_END;
                else if (w_over) w_next = ST_DROP;
            end
            ST_DROP: if (!gmii_rx_dv) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_speed   <= 1'b0;
            r_nib_hi  <= 1'b0;
            r_nib_lo  <= 4'h0;
            r_len     <= 16'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_cnt     <= 3'd0;
            r_er      <= 1'b0;
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_err   <= 1'b0;
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
            for (int i = 0; i < 5; i++) r_line[i] <= 8'h00;
        end else begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_err   <= 1'b0;
            if (w_idle_like) r_speed <= speed_1g;
            if (r_state == ST_PREAMBLE && w_next == ST_DATA) begin
                r_nib_hi <= 1'b0;
                r_len    <= 16'd0;
                r_crc    <= 32'hFFFFFFFF;
                r_cnt    <= 3'd0;
                r_er     <= 1'b0;
            end
            if (r_state == ST_DATA) begin
                if (gmii_rx_er) r_er <= 1'b1;
                if (gmii_rx_dv && !r_speed) begin
                    r_nib_hi <= ~r_nib_hi;
                    if (!r_nib_hi) r_nib_lo <= gmii_rxd[3:0];
                end
                if (w_over) begin
                    r_m_data  <= r_line[D-1];
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b1;
                    r_m_err   <= 1'b1;
                    r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                end else if (w_byte_vld) begin
                    r_line[0] <= w_byte;
                    for (int i = 1; i < 5; i++) r_line[i] <= r_line[i-1];
                    r_len <= r_len + 16'd1;
                    r_crc <= crc32_byte(r_crc, w_byte);
                    if (r_cnt == D_L) begin
                        r_m_data  <= r_line[D-1];
                        r_m_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
            end
            // Frame close one clock after dv drops; the held FCS bytes are simply abandoned
            if (r_state == ST_END) begin
                if (r_cnt == D_L) begin
                    r_m_data  <= r_line[D-1];
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b1;
                    r_m_err   <= w_bad;
                end
                if (r_cnt == D_L && !w_bad) r_ok_cnt  <= r_ok_cnt + CNT_WIDTH'(1);
                else                        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign m_data        = r_m_data;
    assign m_valid       = r_m_valid;
    assign m_last        = r_m_last;
    assign m_err         = r_m_err;
    assign frame_ok_cnt  = r_ok_cnt;
    assign frame_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_rgmii_rx_framer.sv
// tb/tb_rgmii_rx_framer.sv - directed self-checking bench for rgmii_rx_framer
module tb_rgmii_rx_framer;
    logic        clk = 1'b0;
    logic        rst;
    logic        speed_1g;
    logic        dv;
    logic        er;
    logic [7:0]  rxd;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_err;
    logic [31:0] ok_cnt, err_cnt;

    always #4 clk = ~clk;

    rgmii_rx_framer #(
        .MIN_FRAME_LEN(64),
        .MAX_FRAME_LEN(1518),
        .STRIP_FCS(1),
        .CNT_WIDTH(32)
    ) dut (
        .gmii_rx_clk(clk),
        .rst(rst),
        .speed_1g(speed_1g),
        .gmii_rx_dv(dv),
        .gmii_rx_er(er),
        .gmii_rxd(rxd),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_err(m_err),
        .frame_ok_cnt(ok_cnt),
        .frame_err_cnt(err_cnt)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  frm [0:1599];
    logic [7:0]  rx_q [$];
    int          n_last;
    int          last_pos;
    logic        last_err;
    logic        consec;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            rx_q.push_back(m_data);
            if (m_last) begin
                n_last   = n_last + 1;
                last_err = m_err;
                last_pos = rx_q.size();
            end
            if (prev_valid) consec = 1'b1;
        end
        prev_valid = m_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        rx_q.delete();
        n_last   = 0;
        last_pos = 0;
        last_err = 1'b0;
        consec   = 1'b0;
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = {1'b0, c[31:1]} ^ ({32{fb}} & 32'hEDB88320);
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] f;
        for (int i = 0; i < 1600; i++) frm[i] = 8'(i * 7 + 3);
        f = fcs_of(n - 4);
        for (int k = 0; k < 4; k++) frm[n-4+k] = f[8*k +: 8];
    endtask

    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        dv  = v;
        er  = e;
        rxd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic nib, input int er_at, input int rst_at, input int gap);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p = (i == 7) ? 8'hD5 : 8'h55;
            if (nib) begin
                drive(1'b1, 1'b0, {4'h0, p[3:0]});
                drive(1'b1, 1'b0, {4'h0, p[7:4]});
            end else begin
                drive(1'b1, 1'b0, p);
            end
        end
        for (int i = 0; i < n; i++) begin
            p = frm[i];
            if (i == rst_at) rst = 1'b1;
            if (nib) begin
                drive(1'b1, (i == er_at), {4'h0, p[3:0]});
                rst = 1'b0;
                drive(1'b1, 1'b0, {4'h0, p[7:4]});
            end else begin
                drive(1'b1, (i == er_at), p);
                rst = 1'b0;
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_beats(input string tag, input int n);
        int nbad;
        nbad = 0;
        for (int i = 0; i < n && i < rx_q.size(); i++)
            if (rx_q[i] !== frm[i]) nbad++;
        check_eq({tag, "_nbeats"}, rx_q.size(), n);
        check_eq({tag, "_data"}, nbad, 0);
    endtask

    initial begin
        rst      = 1'b1;
        speed_1g = 1'b1;
        dv       = 1'b0;
        er       = 1'b0;
        rxd      = 8'h00;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_err", m_err, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_ok", ok_cnt, 0);
        check_eq("rst_errcnt", err_cnt, 0);
        rst = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 8'h00);

        // T1 byte mode, 64-byte good frame
        build_frame(64);
        clr_mon();
        send_frame(64, 1'b0, -1, -1, 12);
        check_beats("t1", 60);
        check_eq("t1_nlast", n_last, 1);
        check_eq("t1_lastpos", last_pos, 60);
        check_eq("t1_m_err", last_err, 0);
        check_eq("t1_ok", ok_cnt, 1);
        check_eq("t1_errcnt", err_cnt, 0);

        // T2 nibble mode, same frame
        speed_1g = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        clr_mon();
        send_frame(64, 1'b1, -1, -1, 12);
        check_beats("t2", 60);
        check_eq("t2_nlast", n_last, 1);
        check_eq("t2_lastpos", last_pos, 60);
        check_eq("t2_m_err", last_err, 0);
        check_eq("t2_consec", consec, 0);
        check_eq("t2_ok", ok_cnt, 2);
        speed_1g = 1'b1;
        drive(1'b0, 1'b0, 8'h00);

        // T3 one FCS bit flipped
        frm[61] = frm[61] ^ 8'h10;
        clr_mon();
        send_frame(64, 1'b0, -1, -1, 12);
        check_eq("t3_nlast", n_last, 1);
        check_eq("t3_m_err", last_err, 1);
        check_eq("t3_errcnt", err_cnt, 1);
        check_eq("t3_ok", ok_cnt, 2);

        // T4 1600-byte oversize frame: last beat is byte 1514
        build_frame(64);
        clr_mon();
        send_frame(1600, 1'b0, -1, -1, 12);
        check_beats("t4", 1514);
        check_eq("t4_nlast", n_last, 1);
        check_eq("t4_lastpos", last_pos, 1514);
        check_eq("t4_m_err", last_err, 1);
        check_eq("t4_errcnt", err_cnt, 2);

        // T5 rx_er mid-frame, then a 40-byte runt with a valid FCS
        build_frame(64);
        clr_mon();
        send_frame(64, 1'b0, 30, -1, 12);
        check_eq("t5a_nlast", n_last, 1);
        check_eq("t5a_m_err", last_err, 1);
        build_frame(40);
        clr_mon();
        send_frame(40, 1'b0, -1, -1, 12);
        check_beats("t5b", 36);
        check_eq("t5b_m_err", last_err, 1);
        check_eq("t5_errcnt", err_cnt, 4);
        check_eq("t5_ok", ok_cnt, 2);

        // T6 reset at byte 30, then a clean frame
        build_frame(64);
        clr_mon();
        send_frame(40, 1'b0, -1, 30, 12);
        check_eq("t6_nlast", n_last, 0);
        check_eq("t6_ok0", ok_cnt, 0);
        check_eq("t6_err0", err_cnt, 0);
        clr_mon();
        send_frame(64, 1'b0, -1, -1, 12);
        check_beats("t6", 60);
        check_eq("t6_ok1", ok_cnt, 1);
        check_eq("t6_err1", err_cnt, 0);

        // T7 back-to-back: next preamble lands on E+1
        clr_mon();
        send_frame(64, 1'b0, -1, -1, 1);
        send_frame(64, 1'b0, -1, -1, 12);
        check_eq("t7_nlast", n_last, 2);
        check_eq("t7_nbeats", rx_q.size(), 120);
        check_eq("t7_ok", ok_cnt, 3);
        check_eq("t7_err", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
